// File: rtl/ioc_bus_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ioc_bus_pkg
//  Description : Shared constants for the IOC-space bus sequencer. It holds
//                the target index codes, the cycle-speed codes, the FSM state
//                encoding, the read word returned for unmapped space, and the
//                target decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ioc_bus_pkg;

   // Target index codes. The first four also index tgt_cyc/tgt_stb/tgt_ack.
   localparam logic [2:0] TGT_IOC  = 3'd0;
   localparam logic [2:0] TGT_FDC  = 3'd1;
   localparam logic [2:0] TGT_LAT  = 3'd2;
   localparam logic [2:0] TGT_POD  = 3'd3;
   localparam logic [2:0] TGT_NONE = 3'd4;

   // IOC cycle-speed codes, taken from address bits [20:19].
   localparam logic [1:0] SPD_SLOW = 2'd0;
   localparam logic [1:0] SPD_MED  = 2'd1;
   localparam logic [1:0] SPD_FAST = 2'd2;
   localparam logic [1:0] SPD_SYNC = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SYNCW = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF;

   // Decode one target in priority order. Latches only answer at fast speed.
   function automatic logic [2:0] decode_target(input logic       ioc_int,
                                                input logic       sel_fdc,
                                                input logic       sel_lat,
                                                input logic       sel_pod,
                                                input logic [1:0] speed);
      logic [2:0] tgt;
      tgt = TGT_NONE;
      if (ioc_int)                              tgt = TGT_IOC;
      else if (sel_fdc)                         tgt = TGT_FDC;
      else if (sel_lat && (speed == SPD_FAST))  tgt = TGT_LAT;
      else if (sel_pod)                         tgt = TGT_POD;
      return tgt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ioc_bus_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ioc_bus_sched_if
//  Description : Bus bundle between the CPU/MEMC side, the sequencer and the
//                IOC-space peripherals.
//                slave  : the sequencer's view. It takes the wishbone
//                         request, the decode and the target acks/data, and
//                         drives wb_ack, wb_dat_o and the target strobes.
//                master : the environment's view, which is the reverse.
//  Revision    : 1.0  initial release
// ============================================================================
interface ioc_bus_sched_if;
   logic        ioc_cs;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [21:0] wb_adr;       // CPU address [23:2]
   logic [7:1]  ioc_select;
   logic        wb_ack;
   logic [31:0] wb_dat_o;
   logic [3:0]  tgt_cyc;
   logic [3:0]  tgt_stb;
   logic        tgt_we;
   logic [3:0]  tgt_ack;
   logic [7:0]  ioc_dat;
   logic [7:0]  fdc_dat;
   logic [7:0]  lat_dat;
   logic [15:0] pod_dat;

   modport slave (
      input  ioc_cs, wb_cyc, wb_stb, wb_we, wb_adr, ioc_select,
      input  tgt_ack, ioc_dat, fdc_dat, lat_dat, pod_dat,
      output wb_ack, wb_dat_o, tgt_cyc, tgt_stb, tgt_we
   );

   modport master (
      output ioc_cs, wb_cyc, wb_stb, wb_we, wb_adr, ioc_select,
      output tgt_ack, ioc_dat, fdc_dat, lat_dat, pod_dat,
      input  wb_ack, wb_dat_o, tgt_cyc, tgt_stb, tgt_we
   );
endinterface
`default_nettype wire

// File: rtl/ioc_bus_sched_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ioc_cycle_timer
//  Description : Cycle timing for one IOC access. It holds the 8 MHz tick
//                counter (saturating at the speed's minimum), the clkcpu
//                timeout counter, and the 2 MHz alignment used by sync cycles.
//  Ports       : clk, rst             clock, synchronous active-high reset
//                start                clears both counters (SETUP)
//                in_syncw / in_wait   FSM is aligning / waiting
//                speed                latched cycle-speed code
//                clk2m_en / clk8m_en  IOC clock enables
//                aligned              sync alignment reached this cycle
//                expired              tick minimum met, including this cycle
//                timeout              abandon limit reached this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module ioc_cycle_timer
   import ioc_bus_pkg::*;
#(
   parameter int SLOW_TICKS  = 8,
   parameter int MED_TICKS   = 6,
   parameter int FAST_TICKS  = 4,
   parameter int SYNC_TICKS  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_syncw,
   input  logic       in_wait,
   input  logic [1:0] speed,
   input  logic       clk2m_en,
   input  logic       clk8m_en,
   output logic       aligned,
   output logic       expired,
   output logic       timeout
);
   localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [7:0]      limit;
   logic [7:0]      tick_q, tick_d;
   logic [TO_W-1:0] to_q, to_d;

   always_comb begin
      limit = 8'(SYNC_TICKS);
      case (speed)
         SPD_SLOW: limit = 8'(SLOW_TICKS);
         SPD_MED:  limit = 8'(MED_TICKS);
         SPD_FAST: limit = 8'(FAST_TICKS);
         default:  limit = 8'(SYNC_TICKS);
      endcase
   end

   always_comb begin
      tick_d = tick_q;
      to_d   = to_q;
      if (start) begin
         tick_d = '0;
         to_d   = '0;
      end else begin
         // Ticks count only in WAIT. A sync cycle therefore ignores the
         // 8 MHz tick that coincides with its 2 MHz alignment edge.
         if (in_wait && clk8m_en && (tick_q != limit))
            tick_d = tick_q + 8'd1;
         if ((in_wait || in_syncw) && (to_q != TO_LAST))
            to_d = to_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q <= '0;
         to_q   <= '0;
      end else begin
         tick_q <= tick_d;
         to_q   <= to_d;
      end
   end

   assign aligned = in_syncw & clk2m_en;
   // Look ahead one tick so that the last tick and a target ack arriving in
   // the same cycle complete together.
   assign expired = in_wait & ((tick_q == limit) | (clk8m_en & ((tick_q + 8'd1) == limit)));
   assign timeout = (in_wait | in_syncw) & (to_q == TO_LAST);

endmodule
`default_nettype wire

// File: rtl/ioc_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ioc_bus_sched
//  Description : IOC-space bus sequencer. It takes one decoded CPU wishbone
//                cycle, steers it to a single target (IOC, FDC, latches,
//                podules or unmapped), applies the IOC cycle-speed timing,
//                and returns one registered read word with a single ack.
//  Ports       : clkcpu, rst_i       clock, synchronous active-high reset
//                clk2m_en, clk8m_en  IOC clock enables
//                bus                 wishbone + target bundle (slave view)
//                busy                FSM not idle
//                timeout_o           one-cycle pulse when a cycle is abandoned
//  Revision    : 1.0  initial release
// ============================================================================
module ioc_bus_sched #(
   parameter int SLOW_TICKS  = 8,
   parameter int MED_TICKS   = 6,
   parameter int FAST_TICKS  = 4,
   parameter int SYNC_TICKS  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic           clkcpu,
   input  logic           rst_i,
   input  logic           clk2m_en,
   input  logic           clk8m_en,
   ioc_bus_sched_if.slave bus,
   output logic           busy,
   output logic           timeout_o
);
   import ioc_bus_pkg::*;

   state_e      state_q, state_d;
   logic [2:0]  tgt_q, tgt_d;
   logic [1:0]  spd_q, spd_d;
   logic        we_q, we_d;
   logic        got_q, got_d;
   logic        abort_q, abort_d;
   logic        tmo_q, tmo_d;
   logic        after_done_q, after_done_d;
   logic [31:0] dat_q, dat_d;

   logic [2:0]  new_tgt;
   logic [31:0] rd_data;
   logic        ack_sel, got_now, strobe_en;
   logic        t_aligned, t_expired, t_timeout;
   logic        unused_bits;

   assign unused_bits = ^{bus.wb_adr[21:20], bus.wb_adr[16:0],
                          bus.ioc_select[7:6], bus.ioc_select[3:2]};

   // wb_adr holds address bits [23:2], so adr[21] is wb_adr[19] and
   // adr[20:19] is wb_adr[18:17].
   assign new_tgt = decode_target(bus.wb_adr[19], bus.ioc_select[1],
                                  bus.ioc_select[5], bus.ioc_select[4],
                                  bus.wb_adr[18:17]);

   ioc_cycle_timer #(
      .SLOW_TICKS (SLOW_TICKS),
      .MED_TICKS  (MED_TICKS),
      .FAST_TICKS (FAST_TICKS),
      .SYNC_TICKS (SYNC_TICKS),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timer (
      .clk     (clkcpu),
      .rst     (rst_i),
      .start   (state_q == ST_SETUP),
      .in_syncw(state_q == ST_SYNCW),
      .in_wait (state_q == ST_WAIT),
      .speed   (spd_q),
      .clk2m_en(clk2m_en),
      .clk8m_en(clk8m_en),
      .aligned (t_aligned),
      .expired (t_expired),
      .timeout (t_timeout)
   );

   always_comb begin
      rd_data = UNMAPPED_DATA;
      case (tgt_q)
         TGT_IOC: rd_data = {24'd0, bus.ioc_dat};
         TGT_FDC: rd_data = {24'd0, bus.fdc_dat};
         TGT_LAT: rd_data = {24'd0, bus.lat_dat};
         TGT_POD: rd_data = {16'd0, bus.pod_dat};
         default: rd_data = UNMAPPED_DATA;
      endcase
   end

   assign ack_sel   = (tgt_q != TGT_NONE) && bus.tgt_ack[tgt_q[1:0]];
   assign got_now   = got_q | ack_sel;
   // Strobes stay up through the cycle in which the ack is sampled.
   assign strobe_en = (state_q == ST_WAIT) && !got_q && (tgt_q != TGT_NONE);

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      spd_d        = spd_q;
      we_d         = we_q;
      got_d        = got_q;
      abort_d      = abort_q;
      dat_d        = dat_q;
      tmo_d        = 1'b0;
      after_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The cycle right after DONE still carries the old request.
            if (bus.ioc_cs && bus.wb_cyc && bus.wb_stb && !after_done_q)
               state_d = ST_SETUP;
         end
         ST_SETUP: begin
            tgt_d   = new_tgt;
            spd_d   = bus.wb_adr[18:17];
            we_d    = bus.wb_we;
            got_d   = (new_tgt == TGT_NONE);
            abort_d = !bus.wb_cyc;
            if (new_tgt == TGT_NONE)
               dat_d = UNMAPPED_DATA;
            state_d = (bus.wb_adr[18:17] == SPD_SYNC) ? ST_SYNCW : ST_WAIT;
         end
         ST_SYNCW: begin
            if (!bus.wb_cyc)
               abort_d = 1'b1;
            if (t_timeout) begin
               dat_d   = UNMAPPED_DATA;
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end else if (t_aligned) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A dropped wb_cyc only suppresses the final ack. The peripheral
            // cycle itself is never cut short.
            if (!bus.wb_cyc)
               abort_d = 1'b1;
            if (ack_sel && !got_q) begin
               got_d = 1'b1;
               dat_d = rd_data;
            end
            if (t_timeout && !got_now) begin
               dat_d   = UNMAPPED_DATA;
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end else if (t_expired && got_now) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            after_done_d = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkcpu) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         tgt_q        <= TGT_NONE;
         spd_q        <= SPD_SLOW;
         we_q         <= 1'b0;
         got_q        <= 1'b0;
         abort_q      <= 1'b0;
         tmo_q        <= 1'b0;
         after_done_q <= 1'b0;
         dat_q        <= '0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         spd_q        <= spd_d;
         we_q         <= we_d;
         got_q        <= got_d;
         abort_q      <= abort_d;
         tmo_q        <= tmo_d;
         after_done_q <= after_done_d;
         dat_q        <= dat_d;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_tgt
      assign bus.tgt_cyc[i] = strobe_en && (tgt_q == 3'(i));
      assign bus.tgt_stb[i] = strobe_en && (tgt_q == 3'(i));
   end

   assign bus.tgt_we   = we_q;
   assign bus.wb_dat_o = dat_q;
   assign bus.wb_ack   = (state_q == ST_DONE) && bus.wb_cyc && !abort_q;
   assign busy         = (state_q != ST_IDLE);
   assign timeout_o    = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_ioc_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioc_bus_sched
//  Description : Directed bench for ioc_bus_sched. clk8m_en fires every 4th
//                clkcpu cycle and clk2m_en every 16th (when ph == 0). Each
//                request starts at a known phase, so the expected cycle
//                numbers below are worked out by hand. k counts cycles after
//                the request is raised: k=1 is SETUP and k=2 is the first
//                SYNCW/WAIT cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ioc_bus_sched;
   logic       clkcpu = 1'b0;
   logic       rst_i;
   logic [3:0] ph = 4'd0;
   logic       clk2m_en, clk8m_en, busy, timeout_o;

   int n_checks = 0;
   int n_pass   = 0;

   int          r_stb_first, r_stb_last, r_ack_k, r_ack_n, r_tmo_k, r_tmo_n, r_idle_k;
   logic [3:0]  r_stb_or, r_cyc_or;
   logic [31:0] r_dat;
   logic        r_we, r_reaccept;

   ioc_bus_sched_if bus();

   ioc_bus_sched dut (
      .clkcpu   (clkcpu),
      .rst_i    (rst_i),
      .clk2m_en (clk2m_en),
      .clk8m_en (clk8m_en),
      .bus      (bus),
      .busy     (busy),
      .timeout_o(timeout_o)
   );

   always #5 clkcpu = ~clkcpu;
   always @(posedge clkcpu) ph <= ph + 4'd1;
   assign clk8m_en = (ph[1:0] == 2'b00);
   assign clk2m_en = (ph == 4'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clkcpu);
      #1;
   endtask

   task automatic align(input logic [3:0] p);
      for (int i = 0; i < 20 && ph != p; i++) step();
   endtask

   task automatic drop_req();
      bus.ioc_cs = 1'b0;
      bus.wb_cyc = 1'b0;
      bus.wb_stb = 1'b0;
   endtask

   // Raise one request and record what the DUT does until it has been idle
   // for one cycle after finishing. The request stays high through that
   // first idle cycle, which checks that no new cycle is accepted there.
   task automatic run_cycle(input logic we, input logic [21:0] adr, input logic [7:1] sel,
                            input int ack_k, input int ack_bit, input int drop_k,
                            input int max_k);
      r_stb_first = -1; r_stb_last = -1; r_ack_k = -1; r_ack_n = 0;
      r_tmo_k = -1; r_tmo_n = 0; r_idle_k = -1;
      r_stb_or = '0; r_cyc_or = '0; r_dat = '0; r_we = 1'b0; r_reaccept = 1'b1;
      bus.ioc_cs = 1'b1; bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
      bus.wb_we = we; bus.wb_adr = adr; bus.ioc_select = sel;
      for (int k = 1; k <= max_k; k++) begin
         step();
         if (bus.tgt_stb != 4'b0) begin
            if (r_stb_first < 0) r_stb_first = k;
            r_stb_last = k;
         end
         r_stb_or |= bus.tgt_stb;
         r_cyc_or |= bus.tgt_cyc;
         if (bus.wb_ack) begin
            if (r_ack_k < 0) r_ack_k = k;
            r_ack_n++;
         end
         if (timeout_o) begin
            if (r_tmo_k < 0) r_tmo_k = k;
            r_tmo_n++;
         end
         if (k == 2) r_we = bus.tgt_we;
         if (!busy && r_idle_k < 0 && k > 1) begin
            r_idle_k = k;
            r_dat    = bus.wb_dat_o;
         end else if (r_idle_k > 0 && k == r_idle_k + 1) begin
            r_reaccept = busy;
            drop_req();
            break;
         end
         bus.tgt_ack = (k == ack_k) ? 4'(1 << ack_bit) : 4'b0000;
         if (k == drop_k) drop_req();
      end
      drop_req();
      bus.tgt_ack = 4'b0000;
   endtask

   initial begin
      rst_i = 1'b1;
      bus.ioc_cs = 1'b0; bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
      bus.wb_adr = '0; bus.ioc_select = '0; bus.tgt_ack = '0;
      bus.ioc_dat = 8'h11; bus.fdc_dat = 8'h3C; bus.lat_dat = 8'hA5; bus.pod_dat = 16'h1234;
      step(); step(); step();
      check("rst_ack",   bus.wb_ack,   1'b0);
      check("rst_dat",   bus.wb_dat_o, 32'h0);
      check("rst_cyc",   bus.tgt_cyc,  4'h0);
      check("rst_stb",   bus.tgt_stb,  4'h0);
      check("rst_we",    bus.tgt_we,   1'b0);
      check("rst_busy",  busy,         1'b0);
      check("rst_tmo",   timeout_o,    1'b0);
      rst_i = 1'b0;

      // Fast latch read, starting at ph=0. Ticks at k=4,8,12,16, ack at k=5.
      // The 4th tick is at k=16, so DONE (wb_ack) is at k=17.
      align(4'd0);
      run_cycle(1'b0, 22'h040000, 7'h10, 5, 2, -1, 60);
      check("t1_ack_k",     r_ack_k,     17);
      check("t1_ack_n",     r_ack_n,     1);
      check("t1_stb_first", r_stb_first, 2);
      check("t1_stb_last",  r_stb_last,  5);
      check("t1_stb_or",    r_stb_or,    4'b0100);
      check("t1_cyc_or",    r_cyc_or,    4'b0100);
      check("t1_dat",       r_dat,       32'h0000_00A5);
      check("t1_idle_k",    r_idle_k,    18);
      check("t1_no_reacc",  r_reaccept,  1'b0);
      check("t1_tmo_n",     r_tmo_n,     0);

      // Slow FDC write, target acks at once (k=2). The 8th tick is at k=32.
      align(4'd0);
      run_cycle(1'b1, 22'h000000, 7'h01, 2, 1, -1, 80);
      check("t2_we",        r_we,        1'b1);
      check("t2_ack_k",     r_ack_k,     33);
      check("t2_ack_n",     r_ack_n,     1);
      check("t2_stb_first", r_stb_first, 2);
      check("t2_stb_last",  r_stb_last,  2);
      check("t2_stb_or",    r_stb_or,    4'b0010);

      // Podule at fast speed that never acks. The timeout counter is 0 at
      // k=2 and reaches TIMEOUT_CYC-1 = 1023 at k=1025, so DONE is at k=1026.
      align(4'd0);
      run_cycle(1'b0, 22'h040000, 7'h08, -1, 3, -1, 1100);
      check("t5_ack_k",     r_ack_k,     1026);
      check("t5_ack_n",     r_ack_n,     1);
      check("t5_tmo_k",     r_tmo_k,     1026);
      check("t5_tmo_n",     r_tmo_n,     1);
      check("t5_stb_last",  r_stb_last,  1025);
      check("t5_stb_or",    r_stb_or,    4'b1000);
      check("t5_dat",       r_dat,       32'hFFFF_FFFF);

      // Sync podule read, raised at ph=12 (3 ticks after clk2m_en). SYNCW
      // runs k=2..4, aligns at ph=0 (k=4), and WAIT starts at k=5. Ticks at
      // k=8,12,16,20, so DONE is at k=21.
      align(4'd12);
      run_cycle(1'b0, 22'h060000, 7'h08, 6, 3, -1, 60);
      check("t3_stb_first", r_stb_first, 5);
      check("t3_stb_last",  r_stb_last,  6);
      check("t3_ack_k",     r_ack_k,     21);
      check("t3_dat",       r_dat,       32'h0000_1234);

      // Unmapped, medium speed. No strobe; the 6th tick is at k=24.
      align(4'd0);
      run_cycle(1'b0, 22'h020000, 7'h00, -1, 0, -1, 60);
      check("t4_stb_or",    r_stb_or,    4'b0000);
      check("t4_ack_k",     r_ack_k,     25);
      check("t4_ack_n",     r_ack_n,     1);
      check("t4_dat",       r_dat,       32'hFFFF_FFFF);

      // wb_cyc dropped at k=3. The latch still completes (ack at k=4) and
      // the FSM reaches DONE at k=17, but the CPU sees no ack.
      bus.lat_dat = 8'h5A;
      align(4'd0);
      run_cycle(1'b0, 22'h040000, 7'h10, 4, 2, 3, 60);
      check("t7_stb_first", r_stb_first, 2);
      check("t7_stb_last",  r_stb_last,  4);
      check("t7_ack_n",     r_ack_n,     0);
      check("t7_idle_k",    r_idle_k,    18);
      check("t7_no_reacc",  r_reaccept,  1'b0);

      // Reset pulsed in WAIT: all outputs clear on the next edge.
      align(4'd0);
      bus.ioc_cs = 1'b1; bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
      bus.wb_adr = 22'h040000; bus.ioc_select = 7'h10;
      step(); step(); step();
      check("t6_pre_stb",   bus.tgt_stb, 4'b0100);
      check("t6_pre_we",    bus.tgt_we,  1'b1);
      rst_i = 1'b1;
      drop_req();
      step();
      check("t6_ack",  bus.wb_ack,   1'b0);
      check("t6_dat",  bus.wb_dat_o, 32'h0);
      check("t6_cyc",  bus.tgt_cyc,  4'h0);
      check("t6_stb",  bus.tgt_stb,  4'h0);
      check("t6_we",   bus.tgt_we,   1'b0);
      check("t6_busy", busy,         1'b0);
      check("t6_tmo",  timeout_o,    1'b0);
      rst_i = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ioc_bus_sched.md
Name: ioc_bus_sched

Overview:
Sequencer for the IOC-space peripheral bus. It accepts CPU wishbone cycles that MEMC has decoded into IOC space and routes each one to a single target: IOC registers, FDC1772, latches, podules, or unmapped. It applies the IOC cycle-speed timing (slow/medium/fast/sync) using the 2 MHz and 8 MHz clock enables, and returns one registered read word with a single ack. It replaces the combinational per-peripheral gating and read-data mux in the top level.

Parameters:
SLOW_TICKS, 8, clk8m_en ticks minimum for speed 0 (slow)
MED_TICKS, 6, clk8m_en ticks minimum for speed 1 (medium)
FAST_TICKS, 4, clk8m_en ticks minimum for speed 2 (fast)
SYNC_TICKS, 4, clk8m_en ticks after the clk2m_en alignment, for speed 3 (sync)
TIMEOUT_CYC, 1024, clkcpu cycles from SETUP before a target that has not acked is abandoned

Ports:
clkcpu  in  1  system clock; all logic runs on the rising edge
rst_i  in  1  synchronous, active-high reset
clk2m_en  in  1  2 MHz enable from IOC
clk8m_en  in  1  8 MHz enable from IOC
ioc_cs  in  1  MEMC IOC-space decode
wb_cyc, wb_stb, wb_we  in  1 each  CPU wishbone controls
wb_adr  in  22  CPU address [23:2]; speed = adr[20:19], internal-IOC = adr[21]
ioc_select  in  7  IOC bank select [7:1]
wb_ack  out  1  one-cycle completion to the CPU
wb_dat_o  out  32  registered read data
tgt_cyc  out  4  per-target cyc, one-hot: [0] IOC, [1] FDC, [2] latches, [3] podules
tgt_stb  out  4  per-target stb, same encoding as tgt_cyc
tgt_we  out  1  latched wb_we
tgt_ack  in  4  per-target ack, same encoding as tgt_cyc
ioc_dat, fdc_dat, lat_dat  in  8 each  target read data
pod_dat  in  16  podule read data
busy  out  1  high in any state other than IDLE
timeout_o  out  1  one-cycle pulse when a cycle is abandoned

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. rst_i in any state returns the block to IDLE on the next edge with strobes low and no ack.
- Target decode, latched in SETUP, priority order:
  - adr[21] & ~ioc_sext-equivalent, i.e. adr[21] → IOC
  - ioc_select[1] → FDC
  - ioc_select[5] & speed==2 → latches
  - ioc_select[4] → podules
  - otherwise → UNMAPPED
- FSM states: IDLE, SETUP, SYNCW, WAIT, DONE.
- IDLE → SETUP on ioc_cs & wb_cyc & wb_stb. A request is not accepted in the cycle immediately after DONE.
- SETUP (1 cycle):
  - Latch target, speed, we; clear tick and timeout counters.
  - Next state is SYNCW if speed==3, else WAIT.
- SYNCW: hold until clk2m_en=1 (that edge included), then go to WAIT.
- WAIT:
  - Target strobe: tgt_cyc/tgt_stb for the selected target are high from entry until the cycle its tgt_ack is sampled high, inclusive. UNMAPPED drives no strobe.
  - Tick counter: increments on clk8m_en and saturates at the speed's TICKS value.
  - Ack capture: on the cycle tgt_ack is high, latch the read data as below and set the "got" flag.
  - Read data: 8-bit targets zero-extended to 32 bits; podules zero-extended from 16 bits; UNMAPPED = 32'hFFFF_FFFF.
  - UNMAPPED: "got" is forced at entry.
- WAIT → DONE when ticks == TICKS and got=1. Ticks expiring and ack arriving in the same cycle satisfy both conditions together.
- Timeout: if the timeout counter reaches TIMEOUT_CYC-1 in WAIT/SYNCW without ack:
  - Drop strobes, set wb_dat_o = FFFF_FFFF, pulse timeout_o, go to DONE.
- DONE (1 cycle): wb_ack=1 if wb_cyc is still high; then go to IDLE.
- Abort: if wb_cyc falls mid-cycle, the target cycle runs to completion (peripherals are not aborted), but wb_ack is suppressed.
- Latency: minimum SETUP→ack = TICKS clk8m_en ticks plus 2 clkcpu cycles.
- wb_dat_o holds its value until the next capture.

Decomposition:
- Package ioc_bus_pkg:
  - Target index constants: TGT_IOC=0, TGT_FDC=1, TGT_LAT=2, TGT_POD=3, TGT_NONE.
  - Speed codes: SPD_SLOW=0, MED=1, FAST=2, SYNC=3.
  - FSM state encoding.
  - UNMAPPED_DATA = 32'hFFFF_FFFF.
- One sub-module, ioc_cycle_timer: tick and timeout counters plus the SYNCW alignment. Inputs: start, speed, enables. Outputs: expired, timeout.

Test Plan:
- Fast latches read (adr[21]=0, select[5], speed=2), lat_dat=A5, ack after 1 tick → wb_ack only after 4th clk8m_en, wb_dat_o=0x000000A5, tgt_stb[2] high exactly until ack.
- Slow FDC write, tgt_ack immediate → tgt_we=1, wb_ack not before 8th clk8m_en tick, single-cycle ack.
- Sync podule read, request 3 ticks after clk2m_en, pod_dat=1234 → no ticks counted before next clk2m_en, then 4 ticks, wb_dat_o=0x00001234.
- ioc_cs with ioc_select=0, adr[21]=0, speed=1 → tgt_stb=0, ack after 6 ticks, data FFFF_FFFF.
- Podule never acks → ack at TIMEOUT_CYC, data FFFF_FFFF, timeout_o one cycle, strobes low.
- rst_i pulsed in WAIT → all outputs 0 next edge. Separate run: wb_cyc dropped in WAIT → target completes, no wb_ack, busy returns low.
